// File: rtl/adc_fill_packer.sv
// adc_fill_packer: builds one fill record (header, burst_cnt packed ADC words,
// checksum) and pushes it into the 128-bit DDR3 write FIFO.
// Optional feature macro: PACKER_CKSUM_EN (defined: running XOR checksum,
// undefined: checksum word is all zeros; record length is unchanged).
module adc_fill_packer #(
    parameter int CNT_W       = 23,
    parameter int SYNC_STAGES = 2
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_acq_enabled,
    input  logic             i_trig,
    input  logic [23:0]      i_fill_num,
    input  logic [CNT_W-1:0] i_start_addr,
    input  logic [CNT_W-1:0] i_burst_cnt,
    input  logic [63:0]      i_adc_dat,
    input  logic             i_adc_valid,
    output logic             o_adc_rdy,
    output logic [127:0]     o_fifo_dat,
    output logic             o_fifo_wr_en,
    input  logic             i_fifo_full,
    input  logic             i_ddr3_wr_done,
    output logic             o_acq_done,
    output logic [23:0]      o_fill_cntr
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HDR   = 3'd1,
        S_DATA  = 3'd2,
        S_CKSUM = 3'd3,
        S_FLUSH = 3'd4,
        S_DONE  = 3'd5
    } t_state;

    localparam logic [CNT_W:0]   BEAT_ZERO = {(CNT_W+1){1'b0}};
    localparam logic [CNT_W:0]   BEAT_ONE  = {{CNT_W{1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] WORD_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] WORD_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    t_state                 r_state;
    t_state                 w_state_nxt;

    logic [23:0]            r_fill_num;
    logic [CNT_W-1:0]       r_start_addr;
    logic [CNT_W-1:0]       r_burst_cnt;
    logic [CNT_W:0]         r_beats_rem;
    logic [CNT_W-1:0]       r_word_cnt;
    logic [63:0]            r_half;
    logic                   r_half_pending;
    logic [127:0]           r_ow_dat;
    logic                   r_ow_valid;
    logic [23:0]            r_fill_cntr;
    logic [SYNC_STAGES-1:0] r_sync;

    logic                   w_ow_free;
    logic                   w_beat_acc;
    logic                   w_word_load;
    logic                   w_load_hdr;
    logic                   w_load_ck;
    logic                   w_cnt_inc;
    logic                   w_load;
    logic [127:0]           w_load_dat;
    logic [127:0]           w_hdr;
    logic [127:0]           w_word;
    logic [127:0]           w_cksum_word;
    logic [22:0]            w_hdr_addr;
    logic [22:0]            w_hdr_cnt;

    // Header fields are fixed at 23 bits regardless of CNT_W.
    assign w_hdr_addr = 23'(r_start_addr);
    assign w_hdr_cnt  = 23'(r_burst_cnt);
    assign w_hdr      = {2'b01, 26'b0, r_fill_num, w_hdr_addr, 30'b0, w_hdr_cnt};
    assign w_word     = {i_adc_dat, r_half};

    // The output register may take a new word when empty or drained this cycle.
    assign o_fifo_wr_en = r_ow_valid & ~i_fifo_full;
    assign w_ow_free    = ~r_ow_valid | o_fifo_wr_en;
    assign o_adc_rdy    = (r_state == S_DATA) & (r_beats_rem != BEAT_ZERO) &
                          (~r_half_pending | w_ow_free);
    assign w_beat_acc   = o_adc_rdy & i_adc_valid;
    assign w_word_load  = w_beat_acc & r_half_pending;
    assign w_load       = w_load_hdr | w_word_load | w_load_ck;
    assign o_fifo_dat   = r_ow_dat;
    assign o_acq_done   = (r_state == S_DONE);
    assign o_fill_cntr  = r_fill_cntr;

`ifdef PACKER_CKSUM_EN
    logic [127:0] r_cksum;

    function automatic logic [127:0] f_cksum_step(input logic [127:0] acc,
                                                  input logic [127:0] word);
        return acc ^ word;
    endfunction

    // Running XOR over the header and every data word of the current fill
    always_ff @(posedge i_clk) begin
        if (i_reset || !i_acq_enabled) begin
            r_cksum <= 128'b0;
        end else if (w_load_hdr) begin
            r_cksum <= w_hdr;
        end else if (w_word_load) begin
            r_cksum <= f_cksum_step(r_cksum, w_word);
        end
    end

    assign w_cksum_word = r_cksum;
`else
    assign w_cksum_word = 128'b0;
`endif

    // State register; acquisition disable overrides every transition
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else if (!i_acq_enabled) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and output-register load decisions
    always_comb begin
        w_state_nxt = r_state;
        w_load_hdr  = 1'b0;
        w_load_ck   = 1'b0;
        w_cnt_inc   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_trig) begin
                    w_state_nxt = S_HDR;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_HDR: begin
                if (w_ow_free) begin
                    w_load_hdr = 1'b1;
                    if (r_burst_cnt == WORD_ZERO) begin
                        w_state_nxt = S_CKSUM;
                    end else begin
                        w_state_nxt = S_DATA;
                    end
                end else begin
                    w_state_nxt = S_HDR;
                end
            end
            S_DATA: begin
                if ((r_word_cnt == WORD_ZERO) && w_ow_free) begin
                    w_state_nxt = S_CKSUM;
                end else begin
                    w_state_nxt = S_DATA;
                end
            end
            S_CKSUM: begin
                if (w_ow_free) begin
                    w_load_ck   = 1'b1;
                    w_state_nxt = S_FLUSH;
                end else begin
                    w_state_nxt = S_CKSUM;
                end
            end
            S_FLUSH: begin
                if (!r_ow_valid) begin
                    w_cnt_inc   = 1'b1;
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_FLUSH;
                end
            end
            S_DONE: begin
                if (r_sync[SYNC_STAGES-1]) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_DONE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Select which word enters the output register
    always_comb begin
        w_load_dat = w_word;
        if (w_load_hdr) begin
            w_load_dat = w_hdr;
        end else if (w_load_ck) begin
            w_load_dat = w_cksum_word;
        end else begin
            w_load_dat = w_word;
        end
    end

    // Capture fill parameters at the trigger so later input changes are ignored
    always_ff @(posedge i_clk) begin
        if (i_reset || !i_acq_enabled) begin
            r_fill_num   <= 24'b0;
            r_start_addr <= WORD_ZERO;
            r_burst_cnt  <= WORD_ZERO;
        end else if ((r_state == S_IDLE) && i_trig) begin
            r_fill_num   <= i_fill_num;
            r_start_addr <= i_start_addr;
            r_burst_cnt  <= i_burst_cnt;
        end
    end

    // Beat and word counters for the current fill
    always_ff @(posedge i_clk) begin
        if (i_reset || !i_acq_enabled) begin
            r_beats_rem <= BEAT_ZERO;
            r_word_cnt  <= WORD_ZERO;
        end else if ((r_state == S_IDLE) && i_trig) begin
            r_beats_rem <= {i_burst_cnt, 1'b0};
            r_word_cnt  <= i_burst_cnt;
        end else begin
            if (w_beat_acc) begin
                r_beats_rem <= r_beats_rem - BEAT_ONE;
            end
            if (w_word_load) begin
                r_word_cnt <= r_word_cnt - WORD_ONE;
            end
        end
    end

    // Half-word slot: the first beat of each pair waits here for its partner
    always_ff @(posedge i_clk) begin
        if (i_reset || !i_acq_enabled) begin
            r_half         <= 64'b0;
            r_half_pending <= 1'b0;
        end else if (w_beat_acc) begin
            if (r_half_pending) begin
                r_half_pending <= 1'b0;
            end else begin
                r_half         <= i_adc_dat;
                r_half_pending <= 1'b1;
            end
        end
    end

    // Output register: holds the word until the FIFO takes it
    always_ff @(posedge i_clk) begin
        if (i_reset || !i_acq_enabled) begin
            r_ow_dat   <= 128'b0;
            r_ow_valid <= 1'b0;
        end else if (w_load) begin
            r_ow_dat   <= w_load_dat;
            r_ow_valid <= 1'b1;
        end else if (o_fifo_wr_en) begin
            r_ow_valid <= 1'b0;
        end
    end

    // Completed-fill counter, survives aborts and wraps naturally
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_fill_cntr <= 24'b0;
        end else if (i_acq_enabled && w_cnt_inc) begin
            r_fill_cntr <= r_fill_cntr + 24'd1;
        end
    end

    // Synchronizer for the DDR3 writer's DONE indication
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sync <= {SYNC_STAGES{1'b0}};
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_ddr3_wr_done};
        end
    end

endmodule

// File: tb/tb_adc_fill_packer.sv
// Self-checking bench for adc_fill_packer: random stimulus against a
// record-level reference model (header, paired beats, XOR checksum).
module tb_adc_fill_packer;

    localparam int CNT_W = 23;
    localparam int SYNC  = 2;

    logic         clk = 1'b0;
    logic         reset;
    logic         acq_enabled;
    logic         trig;
    logic [23:0]  fill_num;
    logic [22:0]  start_addr;
    logic [22:0]  burst_cnt;
    logic [63:0]  adc_dat;
    logic         adc_valid;
    logic         adc_rdy;
    logic [127:0] fifo_dat;
    logic         fifo_wr_en;
    logic         fifo_full;
    logic         ddr3_wr_done;
    logic         acq_done;
    logic [23:0]  fill_cntr;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_fills = 0;

    logic [127:0] got_q[$];
    logic [63:0]  beat_q[$];
    int           wr_t[$];
    int           beat_t[$];
    int           neg_idx = 0;
    int           rdy_seen = 0;

    always #5 clk = ~clk;

    adc_fill_packer #(.CNT_W(CNT_W), .SYNC_STAGES(SYNC)) dut (
        .i_clk(clk), .i_reset(reset), .i_acq_enabled(acq_enabled), .i_trig(trig),
        .i_fill_num(fill_num), .i_start_addr(start_addr), .i_burst_cnt(burst_cnt),
        .i_adc_dat(adc_dat), .i_adc_valid(adc_valid), .o_adc_rdy(adc_rdy),
        .o_fifo_dat(fifo_dat), .o_fifo_wr_en(fifo_wr_en), .i_fifo_full(fifo_full),
        .i_ddr3_wr_done(ddr3_wr_done), .o_acq_done(acq_done), .o_fill_cntr(fill_cntr)
    );

    // Record FIFO writes and accepted ADC beats away from the clock edge
    always @(negedge clk) begin
        neg_idx++;
        if (fifo_wr_en) begin
            got_q.push_back(fifo_dat);
            wr_t.push_back(neg_idx);
        end
        if (adc_rdy) rdy_seen++;
        if (adc_rdy && adc_valid) begin
            beat_q.push_back(adc_dat);
            beat_t.push_back(neg_idx);
        end
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] f_hdr(input logic [23:0] fn, input logic [22:0] ad,
                                           input logic [22:0] bc);
        return {2'b01, 26'd0, fn, ad, 30'd0, bc};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        got_q.delete();
        beat_q.delete();
        wr_t.delete();
        beat_t.delete();
        rdy_seen = 0;
    endtask

    task automatic start_fill(input logic [23:0] fn, input logic [22:0] ad, input logic [22:0] bc);
        clear_mon();
        fill_num   = fn;
        start_addr = ad;
        burst_cnt  = bc;
        trig       = 1'b1;
        tick();
        trig       = 1'b0;
        fill_num   = 24'($urandom);
        start_addr = 23'($urandom);
        burst_cnt  = 23'($urandom);
    endtask

    // Compare the captured record with the one the rules say should appear
    task automatic check_record(input logic [23:0] fn, input logic [22:0] ad, input int cnt);
        logic [127:0] ck;
        logic [127:0] w;
        chk("n_writes", 128'(got_q.size()), 128'(cnt + 2));
        chk("n_beats", 128'(beat_q.size()), 128'(2 * cnt));
        ck = f_hdr(fn, ad, 23'(cnt));
        if (got_q.size() >= 1) chk("header", got_q[0], ck);
        for (int k = 0; k < cnt; k++) begin
            if (beat_q.size() >= 2 * k + 2 && got_q.size() >= k + 2) begin
                w = {beat_q[2 * k + 1], beat_q[2 * k]};
                chk("data_word", got_q[k + 1], w);
                ck = ck ^ w;
            end
        end
`ifndef PACKER_CKSUM_EN
        ck = 128'd0;
`endif
        if (got_q.size() >= cnt + 2) chk("cksum", got_q[cnt + 1], ck);
    endtask

    // mode 0: random valid/full, 1: streaming, 2: streaming with a 10-cycle full window
    task automatic run_fill(input logic [23:0] fn, input logic [22:0] ad, input int cnt,
                            input int mode);
        int cyc;
        bit bp_done;
        int snap;
        int fall;
        bit stable;
        logic [127:0] d1;
        cyc = 0;
        bp_done = 1'b0;
        start_fill(fn, ad, 23'(cnt));
        while (!acq_done && cyc < 2000) begin
            adc_dat = {$urandom, $urandom};
            if (mode == 0) begin
                adc_valid = ($urandom_range(0, 3) != 0);
                fifo_full = ($urandom_range(0, 3) == 0);
            end else begin
                adc_valid = 1'b1;
                fifo_full = 1'b0;
            end
            if (mode == 2 && !bp_done && got_q.size() >= 2) begin
                bp_done = 1'b1;
                fifo_full = 1'b1;
                snap = got_q.size();
                fall = -1;
                stable = 1'b1;
                d1 = 128'd0;
                for (int i = 1; i <= 10; i++) begin
                    adc_dat = {$urandom, $urandom};
                    tick();
                    if (fall < 0 && !adc_rdy) fall = i;
                    if (i == 1) d1 = fifo_dat;
                    else if (fifo_dat !== d1) stable = 1'b0;
                end
                chk("bp_rdy_fall", 128'(fall >= 0 && fall <= 2), 128'd1);
                chk("bp_stable", 128'(stable), 128'd1);
                chk("bp_no_write", 128'(got_q.size()), 128'(snap));
                chk("bp_rdy_low", 128'(adc_rdy), 128'd0);
                fifo_full = 1'b0;
            end
            tick();
            cyc++;
        end
        chk("done_timeout", 128'(cyc < 2000), 128'd1);
        adc_valid = 1'b0;
        fifo_full = 1'b0;
        check_record(fn, ad, cnt);
        exp_fills++;
        chk("fill_cntr", 128'(fill_cntr), 128'(exp_fills));
        chk("acq_done", 128'(acq_done), 128'd1);
        if (mode != 0 && cnt > 0 && wr_t.size() >= 2 && beat_t.size() >= 2)
            chk("latency", 128'(wr_t[1]), 128'(beat_t[1] + 1));
    endtask

    // Ignored trig in DONE, then the synchronized release back to IDLE
    task automatic done_handshake();
        int snap;
        int n;
        snap = got_q.size();
        fill_num = 24'($urandom);
        burst_cnt = 23'd1;
        trig = 1'b1;
        tick();
        trig = 1'b0;
        tick();
        tick();
        chk("done_hold", 128'(acq_done), 128'd1);
        chk("trig_in_done", 128'(got_q.size()), 128'(snap));
        ddr3_wr_done = 1'b1;
        n = 0;
        do begin
            tick();
            ddr3_wr_done = 1'b0;
            n++;
        end while (acq_done && n < 20);
        chk("done_latency", 128'(n), 128'(SYNC + 1));
        chk("acq_done_fall", 128'(acq_done), 128'd0);
        repeat (4) tick();
        chk("idle_quiet", 128'(got_q.size()), 128'(snap));
    endtask

    initial begin
        int snap;
        int n;
        reset = 1'b1;
        acq_enabled = 1'b1;
        trig = 1'b0;
        fill_num = 24'd0;
        start_addr = 23'd0;
        burst_cnt = 23'd0;
        adc_dat = 64'd0;
        adc_valid = 1'b0;
        fifo_full = 1'b0;
        ddr3_wr_done = 1'b0;
        repeat (3) tick();
        chk("rst_rdy", 128'(adc_rdy), 128'd0);
        chk("rst_wr_en", 128'(fifo_wr_en), 128'd0);
        chk("rst_dat", fifo_dat, 128'd0);
        chk("rst_done", 128'(acq_done), 128'd0);
        chk("rst_cntr", 128'(fill_cntr), 128'd0);
        reset = 1'b0;
        tick();

        // Basic fill
        run_fill(24'd5, 23'h100, 3, 1);
        done_handshake();

        // Zero-length fill
        run_fill(24'($urandom), 23'($urandom), 0, 1);
        chk("zero_rdy", 128'(rdy_seen), 128'd0);
        done_handshake();

        // Backpressure mid-DATA
        run_fill(24'($urandom), 23'($urandom), 6, 2);
        done_handshake();

        // Abort after one data word
        start_fill(24'd9, 23'h55, 23'd4);
        n = 0;
        while (got_q.size() < 2 && n < 100) begin
            adc_valid = 1'b1;
            adc_dat = {$urandom, $urandom};
            tick();
            n++;
        end
        chk("abort_reach", 128'(n < 100), 128'd1);
        acq_enabled = 1'b0;
        tick();
        chk("abort_wr_en", 128'(fifo_wr_en), 128'd0);
        chk("abort_rdy", 128'(adc_rdy), 128'd0);
        chk("abort_done", 128'(acq_done), 128'd0);
        chk("abort_cntr", 128'(fill_cntr), 128'(exp_fills));
        acq_enabled = 1'b1;
        snap = got_q.size();
        repeat (5) tick();
        adc_valid = 1'b0;
        chk("abort_quiet", 128'(got_q.size()), 128'(snap));
        run_fill(24'h00ABCD, 23'h7_0001, 2, 1);
        done_handshake();

        // Random fills under random valid/full
        for (int f = 0; f < 6; f++) begin
            run_fill(24'($urandom), 23'($urandom), $urandom_range(0, 7), 0);
            done_handshake();
        end

        // Reset in the middle of a fill
        start_fill(24'd77, 23'h10, 23'd5);
        repeat (4) begin
            adc_valid = 1'b1;
            adc_dat = {$urandom, $urandom};
            tick();
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        adc_valid = 1'b0;
        chk("mrst_cntr", 128'(fill_cntr), 128'd0);
        chk("mrst_wr_en", 128'(fifo_wr_en), 128'd0);
        chk("mrst_dat", fifo_dat, 128'd0);
        chk("mrst_rdy", 128'(adc_rdy), 128'd0);
        chk("mrst_done", 128'(acq_done), 128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
